// File: rtl/data_memory_pipe.sv
// Single-port synchronous data memory: byte-masked writes, 1- or 2-cycle
// pipelined reads with a valid strobe, and an optional post-reset clearing sweep.
module data_memory_pipe #(
    parameter int unsigned      WIDTH          = 16,
    parameter int unsigned      DEPTH          = 64,
    parameter int unsigned      ADDR_W         = 6,
    parameter int unsigned      READ_LAT       = 1,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                 clk0,
    input  logic                 rstb0,
    input  logic                 csb0,
    input  logic                 web0,
    input  logic [WIDTH/8-1:0]   wmask0,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [WIDTH-1:0]     din0,
    output logic [WIDTH-1:0]     dout0,
    output logic                 rvalid0,
    output logic                 ready0
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W = ADDR_W + 1;

    if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
        $error("data_memory_pipe: WIDTH must be a non-zero multiple of 8");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("data_memory_pipe: READ_LAT must be 1 or 2");
    end
    if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
        $error("data_memory_pipe: DEPTH must be in 1..2**ADDR_W");
    end

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [WIDTH-1:0]    dout_q;
    logic                rvalid_q;

    logic [WIDTH-1:0]    mem [DEPTH];

    logic                accept_c;
    logic                rd_acc_c;
    logic                wr_acc_c;
    logic                in_range_c;
    logic [IDX_W-1:0]    idx_c;
    logic [WIDTH-1:0]    rd_data_c;
    logic                pipe_valid_c;
    logic [WIDTH-1:0]    pipe_data_c;

    // Sweep/run state register; ready mirrors the state being entered
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        ready_d = (state_d == ST_RUN);
    end

    assign accept_c   = ~csb0 & ready_q;
    assign rd_acc_c   = accept_c & web0;
    assign wr_acc_c   = accept_c & ~web0;
    assign in_range_c = ({1'b0, addr0} < CMP_W'(DEPTH));
    assign idx_c      = IDX_W'(addr0);
    assign rd_data_c  = in_range_c ? mem[idx_c] : '0;

    // Array: sweep writes take priority; no accesses are accepted during the sweep anyway
    always_ff @(posedge clk0) begin
        if (state_q == ST_INIT) begin
            mem[IDX_W'(cnt_q)] <= INIT_VALUE;
        end else if (wr_acc_c && in_range_c) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask0[b]) begin
                    mem[idx_c][8*b +: 8] <= din0[8*b +: 8];
                end
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic             s1_valid_q;
        logic [WIDTH-1:0] s1_data_q;

        // Extra array-output stage; captured data is immune to later writes
        always_ff @(posedge clk0 or negedge rstb0) begin
            if (!rstb0) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
            end else begin
                s1_valid_q <= rd_acc_c;
                s1_data_q  <= rd_data_c;
            end
        end

        assign pipe_valid_c = s1_valid_q;
        assign pipe_data_c  = s1_data_q;
    end else begin : g_lat1
        assign pipe_valid_c = rd_acc_c;
        assign pipe_data_c  = rd_data_c;
    end

    // Output stage: dout holds the last completed read
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= pipe_valid_c;
            if (pipe_valid_c) begin
                dout_q <= pipe_data_c;
            end
        end
    end

    assign dout0   = dout_q;
    assign rvalid0 = rvalid_q;
    assign ready0  = ready_q;

endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised successor to the single-port FPGA data memory used by the RiSC-16 core. It has the same synchronous single-port csb0/web0 access style, generalised in word width and depth. It adds per-byte write masks, a selectable 1- or 2-cycle read latency with a read-valid strobe, and an optional post-reset clearing sweep that holds off accesses via ready0. It sits between the core's memory stage (or a bus adapter) and block RAM.

Parameters:
WIDTH, 16, data word width in bits; must be a multiple of 8, else elaboration error.
DEPTH, 64, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W.
ADDR_W, 6, address width.
READ_LAT, 1, read latency in cycles; legal values 1 or 2, else elaboration error.
CLEAR_ON_RESET, 1, 1 = sweep INIT_VALUE into every word after reset; 0 = no sweep, contents preserved.
INIT_VALUE, 0, word written during the clearing sweep.

Ports:
clk0  input  1  clock; all state updates on rising edge.
rstb0  input  1  asynchronous, active-low reset.
csb0  input  1  chip select, active-low.
web0  input  1  write enable, active-low; 1 = read.
wmask0  input  WIDTH/8  byte write mask, active-high; bit i covers din0[8i+7:8i].
addr0  input  ADDR_W  word address.
din0  input  WIDTH  write data.
dout0  output  WIDTH  read data.
rvalid0  output  1  one-cycle pulse; dout0 carries a completed read.
ready0  output  1  1 = requests accepted; 0 = clearing sweep in progress.

Behaviour:
- Reset (rstb0=0, asynchronous): dout0=0, rvalid0=0, ready0=0, sweep counter=0, all read pipeline registers and valid bits cleared.
  - State = INIT if CLEAR_ON_RESET=1, else RUN.
  - The memory array is not reset.
- FSM:
  - INIT: each cycle writes INIT_VALUE to mem[cnt], then cnt++. After the cycle writing cnt=DEPTH-1, go to RUN.
  - RUN: ready0=1. RUN is only left by reset.
  - ready0 is registered and equals (state==RUN). With CLEAR_ON_RESET=1 it rises exactly DEPTH rising edges after reset release. With CLEAR_ON_RESET=0 it rises on the first rising edge after release.
- Acceptance: a request is accepted at a rising edge when csb0=0 and ready0=1. Requests while ready0=0 are dropped silently: no write, no rvalid0.
- Write (web0=0): for each i with wmask0[i]=1, mem[addr0] byte i ← din0 byte i. Unmasked bytes are unchanged. wmask0=0 is a no-op. No rvalid0 for writes.
- Read (web0=1), READ_LAT=1: dout0 updated and rvalid0=1 in the cycle after the accepting edge. This timing is identical to the legacy memory.
- Read (web0=1), READ_LAT=2: array output is registered once more. dout0/rvalid0 appear two cycles after the accepting edge.
- Reads are fully pipelined: back-to-back reads every cycle give rvalid0 every cycle, in request order.
- dout0 holds the last read data until the next read completes. rvalid0 is high for exactly one cycle per accepted read.
- A read accepted in the cycle after a write to the same address returns the new data. With READ_LAT=2, a write accepted while an earlier read is in flight does not alter that read's data.
- Out-of-range address (addr0 ≥ DEPTH):
  - write ignored;
  - read completes normally with dout0=0 and an rvalid0 pulse.
- Reset mid-operation:
  - in-flight reads are discarded, so no rvalid0 pulse emerges after reset;
  - an interrupted sweep restarts from address 0 and takes the full DEPTH cycles;
  - with CLEAR_ON_RESET=0, array contents survive reset.
- No content-initialisation file is read; initial contents come from the sweep or are don't-care.

Test Plan:
1. Sweep timing: WIDTH=16, DEPTH=64, CLEAR_ON_RESET=1, INIT_VALUE=0x0000; release reset → ready0=0 for exactly 64 edges then 1; read addr 63 → dout0=0x0000 with rvalid0 pulse.
2. Latency: write 0xBEEF to addr 5 (wmask0=2'b11), then read addr 5 → READ_LAT=1: rvalid0/dout0=0xBEEF one cycle after accept; READ_LAT=2: two cycles after accept; rvalid0 high one cycle only.
3. Byte mask: write 0x1234 to addr 7 (mask 2'b11), then write 0xAB00 (mask 2'b10), read addr 7 → 0xAB34. Write 0xFFFF with mask 2'b00 → read stays 0xAB34.
4. Requests during sweep: write 0xFFFF to addr 0 and read addr 1 at sweep cycle 10 → no rvalid0 during INIT; after ready0=1, read addr 0 → 0x0000.
5. Reset mid-activity: READ_LAT=2, assert rstb0 at sweep cnt=20, then again one cycle after a read is accepted in RUN → rvalid0 never pulses for the killed read; dout0=0; ready0 low for a full 64 cycles after each release.
6. Boundaries: DEPTH=48, ADDR_W=6 → write 0x5555 to addr 50 ignored; read addr 50 → dout0=0, rvalid0=1. Then four back-to-back reads of addr 0..3 preloaded with 0x0A,0x0B,0x0C,0x0D → four consecutive rvalid0 pulses returning 0x0A..0x0D in order.
